// File: rtl/vote_session_ctrl.sv
// rtl/vote_session_ctrl.sv - one-session ballot collector with majority/tie evaluation
// Optional session timeout enabled by defining VOTE_TIMEOUT_EN.
module vote_session_ctrl #(
    parameter int N_VOTERS = 4,
    parameter int TIMEOUT  = 64,
    localparam int CW      = $clog2(N_VOTERS + 1)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                close,
    input  logic [N_VOTERS-1:0] vote_valid,
    input  logic [N_VOTERS-1:0] vote_yes,
    output logic [N_VOTERS-1:0] vote_ack,
    output logic                dup_err,
    output logic                busy,
    output logic [N_VOTERS-1:0] voted_mask,
    output logic [CW-1:0]       yes_count,
    output logic                win,
    output logic                tie,
    output logic                done,
    output logic                timed_out
);

    if (N_VOTERS < 2 || TIMEOUT < 2) begin : g_param_check
        $error("vote_session_ctrl: N_VOTERS and TIMEOUT must both be >= 2");
    end

    typedef enum logic [1:0] {S_IDLE, S_OPEN, S_EVAL, S_DONE} state_t;

    localparam logic [CW:0] NV = (CW + 1)'(N_VOTERS);

    state_t              state, state_next;
    logic [N_VOTERS-1:0] yes_reg;
    logic [N_VOTERS-1:0] accept;
    logic [N_VOTERS-1:0] mask_next;
    logic                all_voted;
    logic                timeout_exit;
    logic [CW-1:0]       pop;
    logic [CW:0]         pop2;

    assign accept    = (state == S_OPEN) ? (vote_valid & ~voted_mask) : '0;
    assign mask_next = voted_mask | accept;
    assign all_voted = &mask_next;
    assign pop2      = {pop, 1'b0};

    always_comb begin
        pop = '0;
        for (int i = 0; i < N_VOTERS; i++) begin
            pop = pop + CW'(yes_reg[i]);
        end
    end

`ifdef VOTE_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT);

    logic [TW-1:0] cnt;

    // All-voted and close win over the timeout in the same cycle.
    assign timeout_exit = (state == S_OPEN) && (cnt == TW'(TIMEOUT - 1)) && !all_voted && !close;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt       <= '0;
            timed_out <= 1'b0;
        end else if (state == S_IDLE && start) begin
            cnt       <= '0;
            timed_out <= 1'b0;
        end else if (state == S_OPEN) begin
            cnt <= cnt + 1'b1;
            if (timeout_exit) begin
                timed_out <= 1'b1;
            end
        end
    end
`else
    assign timeout_exit = 1'b0;
    assign timed_out    = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: if (start) state_next = S_OPEN;
            S_OPEN: if (all_voted || close || timeout_exit) state_next = S_EVAL;
            S_EVAL: state_next = S_DONE;
            S_DONE: state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_comb begin
        busy = (state != S_IDLE);
        done = (state == S_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vote_ack   <= '0;
            dup_err    <= 1'b0;
            voted_mask <= '0;
            yes_reg    <= '0;
            yes_count  <= '0;
            win        <= 1'b0;
            tie        <= 1'b0;
        end else begin
            vote_ack <= accept;
            dup_err  <= (state == S_OPEN) && |(vote_valid & voted_mask);
            case (state)
                S_IDLE: begin
                    if (start) begin
                        voted_mask <= '0;
                        yes_reg    <= '0;
                        yes_count  <= '0;
                        win        <= 1'b0;
                        tie        <= 1'b0;
                    end
                end
                S_OPEN: begin
                    voted_mask <= mask_next;
                    yes_reg    <= (yes_reg & ~accept) | (vote_yes & accept);
                end
                S_EVAL: begin
                    yes_count <= pop;
                    win       <= (pop2 > NV);
                    tie       <= (pop2 == NV);
                end
                default: ;
            endcase
        end
    end

endmodule
